// File: rtl/enigma_pkg.sv
// Shared types and constants for the enigma table loading path.
// Rotor and plugboard tables are 64 six-bit entries each.
package enigma_pkg;

  localparam int ENTRY_W     = 6;
  localparam int TABLE_DEPTH = 64;

  localparam logic [1:0] TBL_ROTOR_A = 2'd0;
  localparam logic [1:0] TBL_ROTOR_B = 2'd1;
  localparam logic [1:0] TBL_PLUG    = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/enigma_perm_checker.sv
// Tracks which values a table has used and flags a repeated entry.
// The mask restarts at every table boundary; the flag is sticky.
module enigma_perm_checker
  import enigma_pkg::*;
(
  input  logic               clk,
  input  logic               srst_n,
  input  logic               xfer,
  input  logic               tbl_end,
  input  logic [ENTRY_W-1:0] data,
  output logic               err_dup
);

  logic [TABLE_DEPTH-1:0] seen;

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      seen    <= '0;
      err_dup <= 1'b0;
    end else if (xfer) begin
      if (seen[data])
        err_dup <= 1'b1;
      // last entry is still checked against the old table's mask
      if (tbl_end)
        seen <= '0;
      else
        seen[data] <= 1'b1;
    end
  end

endmodule

// File: rtl/enigma_table_loader.sv
// Replays a byte-serial table stream onto the rotor/plugboard load bus.
// Define DUP_CHECK_EN to flag tables that are not permutations.
module enigma_table_loader
  import enigma_pkg::*;
#(
  parameter int NUM_TABLES = 3
) (
  input  logic               clk,
  input  logic               srst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [ENTRY_W-1:0] in_data,
  output logic               in_ready,
  output logic               load,
  output logic [1:0]         table_idx,
  output logic [ENTRY_W-1:0] code_in,
  output logic               busy,
  output logic               done,
  output logic               err_dup
);

  localparam logic [ENTRY_W-1:0] LAST_ENTRY =
    ENTRY_W'(TABLE_DEPTH - 1);
  localparam logic [1:0] LAST_TBL = 2'(NUM_TABLES - 1);

  loader_state_t      state;
  logic [ENTRY_W-1:0] entry_cnt;
  logic [1:0]         cur_tbl;
  logic               xfer;
  logic               last_entry;
  logic               last_tbl;

  assign in_ready   = (state == LOAD);
  assign xfer       = in_valid && in_ready;
  assign last_entry = (entry_cnt == LAST_ENTRY);
  assign last_tbl   = (cur_tbl == LAST_TBL);

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state     <= IDLE;
      entry_cnt <= '0;
      cur_tbl   <= TBL_ROTOR_A;
      load      <= 1'b0;
      table_idx <= TBL_ROTOR_A;
      code_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      load <= xfer;
      if (xfer) begin
        code_in   <= in_data;
        table_idx <= cur_tbl;
        entry_cnt <= entry_cnt + 1'b1;
        if (last_entry && !last_tbl)
          cur_tbl <= cur_tbl + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer && last_entry && last_tbl) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DUP_CHECK_EN
  logic tbl_end;
  assign tbl_end = xfer && last_entry;

  enigma_perm_checker u_perm (
    .clk     (clk),
    .srst_n  (srst_n),
    .xfer    (xfer),
    .tbl_end (tbl_end),
    .data    (in_data),
    .err_dup (err_dup)
  );
`else
  assign err_dup = 1'b0;
`endif

endmodule

// File: tb/tb_enigma_table_loader.sv
// Directed bench for enigma_table_loader.
// Build with DUP_CHECK_EN defined to exercise the duplicate flag.
module tb_enigma_table_loader;

  logic       clk = 1'b0;
  logic       srst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_data = '0;
  logic       in_ready;
  logic       load;
  logic [1:0] table_idx;
  logic [5:0] code_in;
  logic       busy;
  logic       done;
  logic       err_dup;

  enigma_table_loader #(.NUM_TABLES(3)) dut (
    .clk       (clk),
    .srst_n    (srst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .load      (load),
    .table_idx (table_idx),
    .code_in   (code_in),
    .busy      (busy),
    .done      (done),
    .err_dup   (err_dup)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int         mst;
  int         n;
  int         loads;
  int         run;
  int         max_run;
  logic       e_load;
  logic [5:0] e_code;
  logic [1:0] e_tbl;
  logic       e_err;
  logic [63:0] seen [4];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)",
               tag, obs, exp, n, $time);
    end
  endtask

  task automatic check_all();
    chk("load", 32'(load), 32'(e_load));
    chk("code_in", 32'(code_in), 32'(e_code));
    chk("table_idx", 32'(table_idx), 32'(e_tbl));
    chk("in_ready", 32'(in_ready), 32'(mst == 1));
    chk("busy", 32'(busy), 32'(mst == 1));
    chk("done", 32'(done), 32'(mst == 2));
    chk("err_dup", 32'(err_dup), 32'(e_err));
  endtask

  function automatic logic [5:0] data_for(input int k, input bit dup);
    if (dup && k == 74)
      return 6'd5;
    return 6'(k % 64);
  endfunction

  task automatic cyc(input logic st, input logic v,
                     input logic [5:0] d);
    bit x;
    int t;
    start    = st;
    in_valid = v;
    in_data  = d;
    x = v && (mst == 1);
    @(posedge clk);
    #1;
    e_load = x;
    if (x) begin
      t      = n / 64;
      e_code = d;
      e_tbl  = 2'(t);
`ifdef DUP_CHECK_EN
      if (seen[t][d])
        e_err = 1'b1;
`endif
      seen[t][d] = 1'b1;
      n++;
      loads++;
      run++;
      if (run > max_run)
        max_run = run;
      if (n == 192)
        mst = 2;
    end else begin
      run = 0;
    end
    if (st && mst == 0)
      mst = 1;
    start    = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input logic st);
    srst_n   = 1'b0;
    start    = st;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    srst_n  = 1'b1;
    start   = 1'b0;
    mst     = 0;
    n       = 0;
    loads   = 0;
    run     = 0;
    max_run = 0;
    e_load  = 1'b0;
    e_code  = '0;
    e_tbl   = '0;
    e_err   = 1'b0;
    for (int i = 0; i < 4; i++)
      seen[i] = '0;
    check_all();
  endtask

  initial begin
    int guard;
    logic v;
    repeat (2) @(posedge clk);
    #1;
    // start during reset must be ignored
    do_reset(1'b1);
    cyc(1'b0, 1'b0, 6'd0);
    cyc(1'b0, 1'b0, 6'd0);

    // valid held high while idle, then back-to-back identity tables
    repeat (3) cyc(1'b0, 1'b1, 6'd7);
    cyc(1'b1, 1'b1, 6'd7);
    guard = 0;
    while (n < 192 && guard < 300) begin
      cyc(1'b0, 1'b1, data_for(n, 1'b0));
      guard++;
    end
    chk("burst_count", 32'(n), 32'd192);
    chk("burst_run", 32'(max_run), 32'd192);
    repeat (3) cyc(1'b0, 1'b1, 6'd3);
    cyc(1'b1, 1'b0, 6'd0);
    cyc(1'b0, 1'b0, 6'd0);

    // random gaps, with a stray start in LOAD
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 6'd0);
    guard = 0;
    while (n < 192 && guard < 2000) begin
      v = 1'($urandom_range(0, 1));
      cyc(guard == 50, v, data_for(n, 1'b0));
      guard++;
    end
    chk("gap_count", 32'(n), 32'd192);
    chk("gap_loads", 32'(loads), 32'd192);
    cyc(1'b0, 1'b1, 6'd9);

    // reset mid-session at table 1, then reload with a repeated 5
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 6'd0);
    repeat (70) cyc(1'b0, 1'b1, data_for(n, 1'b0));
    chk("mid_tbl", 32'(table_idx), 32'd1);
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 6'd0);
    guard = 0;
    while (n < 192 && guard < 300) begin
      cyc(1'b0, 1'b1, data_for(n, 1'b1));
      guard++;
    end
    chk("dup_count", 32'(n), 32'd192);
`ifdef DUP_CHECK_EN
    chk("dup_final", 32'(err_dup), 32'd1);
`else
    chk("dup_final", 32'(err_dup), 32'd0);
`endif
    cyc(1'b0, 1'b0, 6'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
